// File: rtl/eth_rx_defs.sv
// Shared definitions for the Ethernet receive path.
//   - Preamble / SFD byte values
//   - Frame FSM state encoding
//   - In-band link speed codes
//   - Frame output beat (one byte plus its framing flags)
package eth_rx_defs;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [7:0]  data;
    logic        valid;
    logic        sof;
    logic        eof;
    logic        err;
    logic [15:0] len;
  } frm_beat_t;

endpackage

// File: rtl/rgmii_rx_iddr.sv
// RGMII DDR input capture bank, one IDDR2-equivalent cell per line,
// output aligned to the rising edge (C0 alignment).
//   clk    : receive clock (C0; C1 is its inverse)
//   rst    : async active-high reset
//   d      : DDR pins {ctl, rxd[3:0]}
//   q_rise : value sampled on the rising edge
//   q_fall : value sampled on the following falling edge
// Both outputs change together one rising edge after the rising-edge sample.
module rgmii_rx_iddr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q_rise,
  output logic [W-1:0] q_fall
);

  for (genvar i = 0; i < W; i++) begin : g_line
    logic r_s, f_s, r_q, f_q;

    always_ff @(posedge clk or posedge rst)
      if (rst) r_s <= 1'b0;
      else     r_s <= d[i];

    always_ff @(negedge clk or posedge rst)
      if (rst) f_s <= 1'b0;
      else     f_s <= d[i];

    // Re-time the falling sample onto the rising edge so the pair leaves together.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_q <= 1'b0;
        f_q <= 1'b0;
      end else begin
        r_q <= r_s;
        f_q <= f_s;
      end

    assign q_rise[i] = r_q;
    assign q_fall[i] = f_q;
  end

endmodule

// File: rtl/rgmii_rx_frame.sv
// RGMII receive: DDR capture -> GMII byte stream -> framed bytes.
//   gmii_rx_clk, rst           : sole clock, async active-high reset
//   rgmii_rx_ctl, rgmii_rxd    : RGMII DDR pins from the PHY
//   gmii_rx_dv/er, gmii_rxd    : rebuilt GMII stream (2 cycles after pin sample)
//   frm_data/valid/sof/eof     : post-SFD bytes, one per cycle
//   frm_err, frm_len           : frame status, valid with frm_eof
//   link_up/link_speed/full_duplex : in-band status from inter-frame gaps
module rgmii_rx_frame
  import eth_rx_defs::*;
#(
  parameter int MAX_LEN      = 1522,
  parameter int MAX_PREAMBLE = 15
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        rgmii_rx_ctl,
  input  logic [3:0]  rgmii_rxd,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_er,
  output logic [7:0]  gmii_rxd,
  output logic [7:0]  frm_data,
  output logic        frm_valid,
  output logic        frm_sof,
  output logic        frm_eof,
  output logic        frm_err,
  output logic [15:0] frm_len,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        full_duplex
);

  localparam int          PW        = $clog2(MAX_PREAMBLE + 2);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  logic [4:0] q_rise, q_fall;

  rgmii_rx_iddr #(.W(5)) u_iddr (
    .clk    (gmii_rx_clk),
    .rst    (rst),
    .d      ({rgmii_rx_ctl, rgmii_rxd}),
    .q_rise (q_rise),
    .q_fall (q_fall)
  );

  // GMII stage: ctl on the falling edge carries DV xor ER.
  always_ff @(posedge gmii_rx_clk or posedge rst)
    if (rst) begin
      gmii_rxd   <= '0;
      gmii_rx_dv <= 1'b0;
      gmii_rx_er <= 1'b0;
    end else begin
      gmii_rxd   <= {q_fall[3:0], q_rise[3:0]};
      gmii_rx_dv <= q_rise[4];
      gmii_rx_er <= q_rise[4] ^ q_fall[4];
    end

  // In-band status is only meaningful on plain inter-frame cycles.
  always_ff @(posedge gmii_rx_clk or posedge rst)
    if (rst) begin
      link_up     <= 1'b0;
      link_speed  <= SPD_10;
      full_duplex <= 1'b0;
    end else if (!gmii_rx_dv && !gmii_rx_er) begin
      link_up     <= gmii_rxd[0];
      link_speed  <= gmii_rxd[2:1];
      full_duplex <= gmii_rxd[3];
    end

  rx_state_e   state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [15:0] len_cnt;
  logic [7:0]  hold;
  logic        hold_vld, sof_pend, err_acc;
  logic        pre_over, len_full;
  frm_beat_t   emit;
  logic        take, sfd_hit;

  // pre_cnt counts 0x55 bytes seen so far; one more would exceed the limit.
  assign pre_over = int'(pre_cnt) >= MAX_PREAMBLE;
  // Holding register already carries byte MAX_LEN.
  assign len_full = (len_cnt == MAX_LEN_W);

  always_ff @(posedge gmii_rx_clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (gmii_rx_dv)
          state_nxt = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      ST_PREAMBLE:
        if (!gmii_rx_dv)                                state_nxt = ST_IDLE;
        else if (gmii_rxd == SFD_BYTE)                  state_nxt = ST_DATA;
        else if (gmii_rxd != PREAMBLE_BYTE || pre_over) state_nxt = ST_DROP;
      ST_DATA:
        if (!gmii_rx_dv)   state_nxt = ST_IDLE;
        else if (len_full) state_nxt = ST_DROP;
      ST_DROP:
        if (!gmii_rx_dv) state_nxt = ST_IDLE;
    endcase
  end

  // Frame byte emission: the held byte goes out when its successor arrives,
  // or as the eof byte when dv drops (or the length limit is hit).
  always_comb begin
    emit    = '0;
    take    = 1'b0;
    sfd_hit = (state == ST_PREAMBLE) && gmii_rx_dv && (gmii_rxd == SFD_BYTE);
    if (state == ST_DATA) begin
      if (!gmii_rx_dv) begin
        if (hold_vld) begin
          emit.data  = hold;
          emit.valid = 1'b1;
          emit.sof   = sof_pend;
          emit.eof   = 1'b1;
          emit.err   = err_acc | gmii_rx_er;
          emit.len   = len_cnt;
        end
      end else if (len_full) begin
        emit.data  = hold;
        emit.valid = 1'b1;
        emit.sof   = sof_pend;
        emit.eof   = 1'b1;
        emit.err   = 1'b1;
        emit.len   = len_cnt;
      end else begin
        take = 1'b1;
        if (hold_vld) begin
          emit.data  = hold;
          emit.valid = 1'b1;
          emit.sof   = sof_pend;
        end
      end
    end
  end

  always_ff @(posedge gmii_rx_clk or posedge rst)
    if (rst) begin
      pre_cnt   <= '0;
      len_cnt   <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      sof_pend  <= 1'b0;
      err_acc   <= 1'b0;
      frm_data  <= '0;
      frm_valid <= 1'b0;
      frm_sof   <= 1'b0;
      frm_eof   <= 1'b0;
      frm_err   <= 1'b0;
      frm_len   <= '0;
    end else begin
      frm_data  <= emit.data;
      frm_valid <= emit.valid;
      frm_sof   <= emit.sof;
      frm_eof   <= emit.eof;
      frm_err   <= emit.err;
      frm_len   <= emit.len;

      // Outside PREAMBLE, preload 1 so the 0x55 that enters PREAMBLE is counted.
      if (state != ST_PREAMBLE) pre_cnt <= PW'(1);
      else                      pre_cnt <= pre_cnt + 1'b1;

      if (sfd_hit) begin
        len_cnt  <= '0;
        hold_vld <= 1'b0;
        sof_pend <= 1'b1;
        err_acc  <= 1'b0;
      end else if (take) begin
        hold     <= gmii_rxd;
        hold_vld <= 1'b1;
        len_cnt  <= len_cnt + 16'd1;
        err_acc  <= err_acc | gmii_rx_er;
        if (emit.valid) sof_pend <= 1'b0;
      end else if (emit.eof) begin
        hold_vld <= 1'b0;
        sof_pend <= 1'b0;
        err_acc  <= 1'b0;
      end
    end

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Bench for rgmii_rx_frame: directed and randomized RGMII traffic, checked
// against a frame-level reference model (preamble/SFD parsing, truncation,
// error OR-reduction) and a per-cycle history of driven bytes.
module tb_rgmii_rx_frame;
  import eth_rx_defs::*;

  localparam int MAX_LEN = 1522;
  localparam int MAX_PRE = 15;
  localparam int HN      = 16384;

  logic        gmii_rx_clk = 1'b0;
  logic        rst;
  logic        rgmii_rx_ctl;
  logic [3:0]  rgmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  gmii_rxd, frm_data;
  logic        frm_valid, frm_sof, frm_eof, frm_err;
  logic [15:0] frm_len;
  logic        link_up, full_duplex;
  logic [1:0]  link_speed;

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  rgmii_rx_frame #(.MAX_LEN(MAX_LEN), .MAX_PREAMBLE(MAX_PRE)) dut (
    .gmii_rx_clk (gmii_rx_clk),
    .rst         (rst),
    .rgmii_rx_ctl(rgmii_rx_ctl),
    .rgmii_rxd   (rgmii_rxd),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_er  (gmii_rx_er),
    .gmii_rxd    (gmii_rxd),
    .frm_data    (frm_data),
    .frm_valid   (frm_valid),
    .frm_sof     (frm_sof),
    .frm_eof     (frm_eof),
    .frm_err     (frm_err),
    .frm_len     (frm_len),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .full_duplex (full_duplex)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge gmii_rx_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per rising-edge history of what was on the pins.
  bit         hv [HN];
  bit         hdv[HN];
  bit         her[HN];
  logic [7:0] hb [HN];

  typedef struct { logic [7:0] b; logic er; int c; } beat_t;
  typedef struct { int len; logic err; int ec; } hdr_t;

  beat_t      burst[$];
  bit         burst_done;
  hdr_t       hdr[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] act[$];
  logic [3:0] st_exp;

  // Index of the SFD if the burst so far opens with an acceptable preamble, else -1.
  function automatic int sfd_idx();
    int k = 0;
    while (k < burst.size() && burst[k].b == PREAMBLE_BYTE) k++;
    if (k == 0 || k > MAX_PRE || k == burst.size()) return -1;
    if (burst[k].b != SFD_BYTE) return -1;
    return k;
  endfunction

  task automatic push_frame(input int s, input int n, input logic err, input int ec);
    hdr.push_back('{n, err, ec});
    for (int i = 0; i < n; i++) exp_bytes.push_back(burst[s + 1 + i].b);
  endtask

  // Frame model: decide the expected frame as soon as it is determined.
  task automatic frame_track(input logic dv, input logic er, input logic [7:0] b);
    int s, n;
    logic e;
    if (dv) begin
      burst.push_back('{b, er, cyc});
      if (!burst_done) begin
        s = sfd_idx();
        if (s >= 0 && burst.size() - s - 1 > MAX_LEN) begin
          push_frame(s, MAX_LEN, 1'b1, burst[s + 1 + MAX_LEN].c + 3);
          burst_done = 1'b1;
        end
      end
    end else begin
      if (burst.size() > 0 && !burst_done) begin
        s = sfd_idx();
        n = burst.size() - s - 1;
        if (s >= 0 && n > 0) begin
          e = 1'b0;
          for (int i = 0; i < n; i++) e |= burst[s + 1 + i].er;
          push_frame(s, n, e, cyc + 3);
        end
      end
      burst.delete();
      burst_done = 1'b0;
    end
  endtask

  // One GMII byte per call: low nibble/DV before the rising edge,
  // high nibble/DV^ER before the falling edge.
  task automatic drv(input logic dv, input logic er, input logic [7:0] b);
    @(negedge gmii_rx_clk); #1;
    rgmii_rx_ctl = dv;
    rgmii_rxd    = b[3:0];
    @(posedge gmii_rx_clk); #1;
    rgmii_rx_ctl = dv ^ er;
    rgmii_rxd    = b[7:4];
    if (cyc < HN) begin
      hv[cyc] = 1'b1; hdv[cyc] = dv; her[cyc] = er; hb[cyc] = b;
    end
    frame_track(dv, er, b);
  endtask

  task automatic idle(input int n, input logic [3:0] nib);
    repeat (n) drv(1'b0, 1'b0, {nib, nib});
  endtask

  task automatic send_frame(input int npre, input int ndata, input int er_at,
                            input logic [7:0] sfd, input bit rnd);
    for (int i = 0; i < npre; i++) drv(1'b1, 1'b0, PREAMBLE_BYTE);
    drv(1'b1, 1'b0, sfd);
    for (int i = 0; i < ndata; i++)
      drv(1'b1, i == er_at, rnd ? 8'($urandom) : 8'(i));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dv"},   gmii_rx_dv,  0);
    chk({tag, "_er"},   gmii_rx_er,  0);
    chk({tag, "_rxd"},  gmii_rxd,    0);
    chk({tag, "_fv"},   frm_valid,   0);
    chk({tag, "_fd"},   frm_data,    0);
    chk({tag, "_sof"},  frm_sof,     0);
    chk({tag, "_eof"},  frm_eof,     0);
    chk({tag, "_ferr"}, frm_err,     0);
    chk({tag, "_flen"}, frm_len,     0);
    chk({tag, "_link"}, link_up,     0);
    chk({tag, "_spd"},  link_speed,  0);
    chk({tag, "_fdx"},  full_duplex, 0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    rgmii_rx_ctl = 1'b0;
    rgmii_rxd    = 4'h0;
    burst.delete();
    burst_done = 1'b0;
    act.delete();
    st_exp = 4'h0;
    for (int k = cyc - 3; k <= cyc; k++) if (k >= 0 && k < HN) hv[k] = 1'b0;
    @(negedge gmii_rx_clk);
    chk_all_zero("rst_mid");
    repeat (3) @(negedge gmii_rx_clk);
    #1 rst = 1'b0;
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge gmii_rx_clk) begin
    hdr_t       h;
    logic [7:0] eb;
    if (!rst && cyc >= 3 && cyc < HN + 3) begin
      if (hv[cyc - 2]) begin
        chk("gmii_dv",  gmii_rx_dv, hdv[cyc - 2]);
        chk("gmii_er",  gmii_rx_er, her[cyc - 2]);
        chk("gmii_rxd", gmii_rxd,   hb[cyc - 2]);
      end
      if (hv[cyc - 3] && !hdv[cyc - 3] && !her[cyc - 3]) st_exp = hb[cyc - 3][3:0];
      chk("link_up",     link_up,     st_exp[0]);
      chk("link_speed",  link_speed,  st_exp[2:1]);
      chk("full_duplex", full_duplex, st_exp[3]);
      if (frm_valid) begin
        chk("frm_sof", frm_sof, act.size() == 0);
        act.push_back(frm_data);
        if (frm_eof) begin
          chk("frame_expected", hdr.size() > 0, 1);
          if (hdr.size() > 0) begin
            h = hdr.pop_front();
            chk("frm_len",   frm_len,    h.len);
            chk("frm_bytes", act.size(), h.len);
            chk("frm_err",   frm_err,    h.err);
            chk("eof_cycle", cyc,        h.ec);
            for (int i = 0; i < h.len; i++) begin
              eb = exp_bytes.pop_front();
              if (i < act.size()) chk("frm_data", act[i], eb);
            end
          end
          act.delete();
        end
      end else begin
        chk("frm_idle", {frm_sof, frm_eof, frm_err, frm_len, frm_data}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int npre, ndata, er_at, gap;
    logic [7:0] sfd;
    rst = 1'b1;
    rgmii_rx_ctl = 1'b0;
    rgmii_rxd    = 4'h0;
    burst_done   = 1'b0;
    st_exp       = 4'h0;
    @(negedge gmii_rx_clk);
    chk_all_zero("rst_init");
    repeat (2) @(negedge gmii_rx_clk);
    #1 rst = 1'b0;

    // In-band status: link up, 1000M, full duplex.
    idle(5, 4'hD);
    chk("st_link", link_up, 1);
    chk("st_spd",  link_speed, SPD_1000);
    chk("st_fdx",  full_duplex, 1);

    // Good 64-byte frame; status must hold across it.
    send_frame(7, 64, -1, SFD_BYTE, 0);
    idle(3, 4'hD);

    // Status back to all-zero.
    idle(5, 4'h0);
    chk("st0_link", link_up, 0);
    chk("st0_spd",  link_speed, SPD_10);
    chk("st0_fdx",  full_duplex, 0);

    // Same frame with RX_ER on byte 10.
    send_frame(7, 64, 10, SFD_BYTE, 0);
    idle(3, 4'h0);

    // Bad preamble, then a good 10-byte frame after a 1-cycle gap.
    drv(1'b1, 1'b0, 8'h55);
    drv(1'b1, 1'b0, 8'h55);
    drv(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 20; i++) drv(1'b1, 1'b0, 8'($urandom));
    idle(1, 4'h0);
    send_frame(7, 10, -1, SFD_BYTE, 1);
    idle(3, 4'h0);

    // Oversize: 1530 bytes after the SFD.
    send_frame(7, 1530, -1, SFD_BYTE, 0);
    idle(3, 4'h0);

    // Boundary preamble lengths: 15 accepted, 16 dropped.
    send_frame(MAX_PRE, 5, -1, SFD_BYTE, 1);
    idle(1, 4'h0);
    send_frame(MAX_PRE + 1, 5, -1, SFD_BYTE, 1);
    idle(2, 4'h0);

    // Randomized traffic, including 1-cycle gaps and random status nibbles.
    for (int f = 0; f < 40; f++) begin
      npre  = $urandom_range(1, 16);
      ndata = $urandom_range(0, 80);
      er_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : -1;
      sfd   = ($urandom_range(0, 7) == 0) ? 8'hA5 : SFD_BYTE;
      send_frame(npre, ndata, er_at, sfd, 1);
      gap = $urandom_range(1, 3);
      idle(gap, 4'($urandom));
    end
    idle(3, 4'h0);

    // Reset in the middle of a frame, then a single-byte frame.
    send_frame(7, 30, -1, SFD_BYTE, 1);
    do_reset();
    idle(2, 4'h0);
    send_frame(7, 1, -1, SFD_BYTE, 1);
    idle(5, 4'h0);

    chk("frames_left",   hdr.size(), 0);
    chk("partial_frame", act.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
